// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: req/ack access, pipeline stall/bubble, load-data latch,
// misalign/timeout faults. Optional stall performance counter: define MEM_STALL_COUNTER_EN.
module mem_access_ctrl #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int DATA_W         = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ME_MemRead,
   input  logic              ME_MemWrite,
   input  logic [1:0]        ME_mem_size,
   input  logic [DATA_W-1:0] ME_Addr,
   input  logic [DATA_W-1:0] ME_Din,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] ME_Dout,
   output logic              pipe_stall,
   output logic              wb_bubble,
   output logic              access_fault,
   output logic [31:0]       stall_cycles,
   output logic [1:0]        state_dbg
);

   // state_dbg encoding: 0 = IDLE, 1 = BUSY, 2 = DONE.
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [1:0] state;
   logic [7:0] wait_cnt;
   logic       access;
   logic       misaligned;

   assign access = ME_MemRead | ME_MemWrite;

   always_comb begin
      misaligned = 1'b0;
      case (ME_mem_size)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = ME_Addr[0];
         default: misaligned = |ME_Addr[1:0];
      endcase
   end

   // Handshake: mem_req is held high (with mem_we/mem_addr/mem_wdata stable) from the cycle
   // after the access is accepted until the cycle after mem_ack is seen or the access times
   // out; mem_ack is a single-cycle strobe and mem_rdata is only consumed together with it.
   assign pipe_stall = ((state == IDLE) && access) || (state == BUSY);
   assign wb_bubble  = pipe_stall;
   assign state_dbg  = state;

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         ME_Dout      <= '0;
         access_fault <= 1'b0;
      end else begin
         access_fault <= 1'b0;
         case (state)
            IDLE: begin
               if (access) begin
                  if (misaligned) begin
                     access_fault <= 1'b1;
                     ME_Dout      <= '0;
                     state        <= DONE;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= ME_MemWrite;
                     mem_addr  <= ME_Addr;
                     mem_wdata <= ME_Din;
                     wait_cnt  <= '0;
                     state     <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (!mem_we) ME_Dout <= mem_rdata;
                  state <= DONE;
               end else if (wait_cnt == TMO_LAST) begin
                  mem_req      <= 1'b0;
                  access_fault <= 1'b1;
                  ME_Dout      <= '0;
                  state        <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_STALL_COUNTER_EN
   // Saturating count of every stalled clock since reset.
   always_ff @(posedge clock) begin
      if (reset)
         stall_cycles <= '0;
      else if (pipe_stall && (stall_cycles != 32'hFFFF_FFFF))
         stall_cycles <= stall_cycles + 32'd1;
   end
`else
   assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: per-cycle expectations built from access latency
// rules, a negedge compare process, and literal checks on stall/req/fault counts.
module tb_mem_access_ctrl;
   localparam int TMO = 16;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
`ifdef MEM_STALL_COUNTER_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clock, reset;
   logic        ME_MemRead, ME_MemWrite;
   logic [1:0]  ME_mem_size;
   logic [31:0] ME_Addr, ME_Din;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, ME_Dout;
   logic        pipe_stall, wb_bubble, access_fault;
   logic [31:0] stall_cycles;
   logic [1:0]  state_dbg;

   typedef struct packed {
      logic        chk;
      logic [1:0]  st;
      logic        stall;
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] dout;
      logic        fault;
      logic [31:0] cnt;
   } exp_t;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [1:0]  sz;
      logic [31:0] addr;
      logic [31:0] din;
      logic [31:0] rdata;
      int          wait_n;
   } vec_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   stall_obs = 0, req_obs = 0, fault_obs = 0;
   int   s0, r0, f0;

   logic        m_we;
   logic [31:0] m_addr, m_wdata, m_dout, m_cnt;

   mem_access_ctrl #(.TIMEOUT_CYCLES(TMO), .DATA_W(32)) dut (
      .clock(clock), .reset(reset),
      .ME_MemRead(ME_MemRead), .ME_MemWrite(ME_MemWrite), .ME_mem_size(ME_mem_size),
      .ME_Addr(ME_Addr), .ME_Din(ME_Din),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ME_Dout(ME_Dout),
      .pipe_stall(pipe_stall), .wb_bubble(wb_bubble), .access_fault(access_fault),
      .stall_cycles(stall_cycles), .state_dbg(state_dbg)
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic model_reset();
      m_we = 1'b0; m_addr = '0; m_wdata = '0; m_dout = '0; m_cnt = '0;
   endtask

   // Expectation for the current cycle; registered fields come from the model variables.
   task automatic push(input bit chk, input logic [1:0] st, input logic stall,
                       input logic req, input logic fault);
      exp_t e;
      e.chk = chk; e.st = st; e.stall = stall; e.req = req; e.we = m_we;
      e.addr = m_addr; e.wdata = m_wdata; e.dout = m_dout; e.fault = fault; e.cnt = m_cnt;
      exp_q.push_back(e);
      if (CNT_EN && stall && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
   endtask

   task automatic clear_inputs();
      ME_MemRead = 1'b0; ME_MemWrite = 1'b0; ME_mem_size = 2'd0;
      ME_Addr = '0; ME_Din = '0; mem_ack = 1'b0; mem_rdata = '0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset(input int n);
      reset = 1'b1;
      clear_inputs();
      model_reset();
      for (int i = 0; i < n; i++) begin
         push(i > 0, ST_IDLE, 1'b0, 1'b0, 1'b0);
         tick();
      end
      reset = 1'b0;
   endtask

   task automatic idle(input int n, input bit noise);
      clear_inputs();
      for (int i = 0; i < n; i++) begin
         mem_ack   = noise;
         mem_rdata = 32'h5A5A_0000 + 32'(i);
         push(1'b1, ST_IDLE, 1'b0, 1'b0, 1'b0);
         tick();
      end
      mem_ack = 1'b0;
   endtask

   // wait_n < 0 withholds the ack so the access times out.
   task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic [31:0] addr, input logic [31:0] din,
                             input int wait_n, input logic [31:0] rdata);
      logic mis;
      mis = ((sz == 2'd1) && addr[0]) || (sz[1] && (addr[1:0] != 2'b00));
      ME_MemRead = rd; ME_MemWrite = wr; ME_mem_size = sz; ME_Addr = addr; ME_Din = din;
      mem_ack = 1'b0; mem_rdata = 32'hFFFF_0000;
      push(1'b1, ST_IDLE, 1'b1, 1'b0, 1'b0);
      tick();
      if (mis) begin
         m_dout = '0;
         push(1'b1, ST_DONE, 1'b0, 1'b0, 1'b1);
         tick();
         return;
      end
      m_addr = addr; m_wdata = din; m_we = wr;
      if (wait_n < 0) begin
         for (int i = 0; i < TMO; i++) begin
            mem_rdata = 32'hBAD0_0000 + 32'(i);
            push(1'b1, ST_BUSY, 1'b1, 1'b1, 1'b0);
            tick();
         end
         m_dout = '0;
         push(1'b1, ST_DONE, 1'b0, 1'b0, 1'b1);
         tick();
      end else begin
         for (int i = 0; i <= wait_n; i++) begin
            mem_ack   = (i == wait_n);
            mem_rdata = (i == wait_n) ? rdata : 32'hBAD0_0000 + 32'(i);
            push(1'b1, ST_BUSY, 1'b1, 1'b1, 1'b0);
            tick();
         end
         mem_ack = 1'b0;
         if (!wr) m_dout = rdata;
         push(1'b1, ST_DONE, 1'b0, 1'b0, 1'b0);
         tick();
      end
   endtask

   // ---------------- scoreboard / compare ----------------
   always @(negedge clock) begin : compare
      exp_t e;
      stall_obs += int'(pipe_stall);
      req_obs   += int'(mem_req);
      fault_obs += int'(access_fault);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (e.chk) begin
            check("state", 32'(state_dbg), 32'(e.st));
            check("pipe_stall", 32'(pipe_stall), 32'(e.stall));
            check("wb_bubble", 32'(wb_bubble), 32'(e.stall));
            check("mem_req", 32'(mem_req), 32'(e.req));
            check("access_fault", 32'(access_fault), 32'(e.fault));
            check("ME_Dout", ME_Dout, e.dout);
            check("stall_cycles", stall_cycles, e.cnt);
            if (e.req) begin
               check("mem_we", 32'(mem_we), 32'(e.we));
               check("mem_addr", mem_addr, e.addr);
               check("mem_wdata", mem_wdata, e.wdata);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   vec_t vecs[6];

   initial begin
      reset = 1'b1;
      clear_inputs();
      model_reset();
      vecs[0] = '{rd:1'b1, wr:1'b0, sz:2'd0, addr:32'h107, din:32'h0,        rdata:32'h0000_00A5, wait_n:1};
      vecs[1] = '{rd:1'b0, wr:1'b1, sz:2'd1, addr:32'h102, din:32'hBEEF,     rdata:32'h0,         wait_n:0};
      vecs[2] = '{rd:1'b1, wr:1'b1, sz:2'd2, addr:32'h040, din:32'h11223344, rdata:32'h99999999,  wait_n:2};
      vecs[3] = '{rd:1'b1, wr:1'b0, sz:2'd2, addr:32'h102, din:32'h0,        rdata:32'h0,         wait_n:0};
      vecs[4] = '{rd:1'b1, wr:1'b0, sz:2'd3, addr:32'h101, din:32'h0,        rdata:32'h0,         wait_n:0};
      vecs[5] = '{rd:1'b1, wr:1'b0, sz:2'd1, addr:32'h106, din:32'h0,        rdata:32'h0000_7E57, wait_n:4};
      tick();
      do_reset(3);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_ME_Dout", ME_Dout, 32'd0);
      check("rst_stall_cycles", stall_cycles, 32'd0);
      idle(2, 1'b1);

      // aligned word load, zero wait
      s0 = stall_obs; r0 = req_obs; f0 = fault_obs;
      run_access(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
      check("ld_stall_len", 32'(stall_obs - s0), 32'd2);
      check("ld_req_len", 32'(req_obs - r0), 32'd1);
      check("ld_faults", 32'(fault_obs - f0), 32'd0);
      check("ld_dout", ME_Dout, 32'hDEAD_BEEF);
      idle(2, 1'b1);

      // word store, three wait cycles
      s0 = stall_obs; r0 = req_obs;
      run_access(1'b0, 1'b1, 2'd2, 32'h204, 32'h1234_5678, 3, 32'h0);
      check("st_stall_len", 32'(stall_obs - s0), 32'd5);
      check("st_req_len", 32'(req_obs - r0), 32'd4);
      check("st_addr", mem_addr, 32'h204);
      check("st_wdata", mem_wdata, 32'h1234_5678);
      check("st_we", 32'(mem_we), 32'd1);
      check("st_dout_kept", ME_Dout, 32'hDEAD_BEEF);
      idle(1, 1'b0);

      // misaligned half load
      s0 = stall_obs; r0 = req_obs; f0 = fault_obs;
      run_access(1'b1, 1'b0, 2'd1, 32'h103, 32'h0, 0, 32'h0);
      check("mis_stall_len", 32'(stall_obs - s0), 32'd1);
      check("mis_req_len", 32'(req_obs - r0), 32'd0);
      check("mis_faults", 32'(fault_obs - f0), 32'd1);
      check("mis_dout", ME_Dout, 32'd0);
      idle(1, 1'b0);

      for (int v = 0; v < 6; v++) begin
         run_access(vecs[v].rd, vecs[v].wr, vecs[v].sz, vecs[v].addr, vecs[v].din,
                    vecs[v].wait_n, vecs[v].rdata);
         idle(1, 1'b1);
      end

      // load with ack withheld
      s0 = stall_obs; r0 = req_obs; f0 = fault_obs;
      run_access(1'b1, 1'b0, 2'd2, 32'h500, 32'h0, -1, 32'h0);
      check("tmo_req_len", 32'(req_obs - r0), 32'd16);
      check("tmo_stall_len", 32'(stall_obs - s0), 32'd17);
      check("tmo_faults", 32'(fault_obs - f0), 32'd1);
      check("tmo_dout", ME_Dout, 32'd0);
      idle(2, 1'b0);

      // reset on the third BUSY cycle, then a late ack
      ME_MemRead = 1'b1; ME_mem_size = 2'd2; ME_Addr = 32'h300; ME_Din = 32'h0;
      push(1'b1, ST_IDLE, 1'b1, 1'b0, 1'b0);
      tick();
      m_addr = 32'h300; m_wdata = 32'h0; m_we = 1'b0;
      push(1'b1, ST_BUSY, 1'b1, 1'b1, 1'b0);
      tick();
      push(1'b1, ST_BUSY, 1'b1, 1'b1, 1'b0);
      tick();
      reset = 1'b1;
      push(1'b1, ST_BUSY, 1'b1, 1'b1, 1'b0);
      tick();
      model_reset();
      reset = 1'b0;
      clear_inputs();
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      push(1'b1, ST_IDLE, 1'b0, 1'b0, 1'b0);
      tick();
      mem_ack = 1'b0;
      check("rstbusy_req", 32'(mem_req), 32'd0);
      check("rstbusy_dout", ME_Dout, 32'd0);
      idle(2, 1'b0);

      // back-to-back zero-wait loads from a fresh reset
      do_reset(2);
      s0 = stall_obs;
      run_access(1'b1, 1'b0, 2'd2, 32'h010, 32'h0, 0, 32'h0000_0001);
      run_access(1'b1, 1'b0, 2'd2, 32'h014, 32'h0, 0, 32'h0000_0002);
      check("b2b_stall_len", 32'(stall_obs - s0), 32'd4);
      check("b2b_counter", stall_cycles, CNT_EN ? 32'd4 : 32'd0);
      check("b2b_dout", ME_Dout, 32'h0000_0002);
      idle(2, 1'b0);

      @(negedge clock);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage of the 5-stage pipeline. Memory uses a req/ack handshake with variable latency.
- While an access is in flight it freezes the upstream stages (PC, IF/ID, ID/EX, EX/MEM) and injects a bubble into the MEM/WB register.
- It latches read data so WB sees a stable value when the instruction advances.
- It detects misaligned and timed-out accesses and reports them as faults.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in BUSY without mem_ack before the access is aborted; legal range 2..255.
- DATA_W, 32: data and address width.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ME_MemRead  in  1  MEM-stage instruction is a load.
- ME_MemWrite  in  1  MEM-stage instruction is a store.
- ME_mem_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word.
- ME_Addr  in  DATA_W  byte address from ME_Alu_Result.
- ME_Din  in  DATA_W  store data.
- mem_req  out  1  request to data memory.
- mem_we  out  1  1=write, 0=read; valid while mem_req=1.
- mem_addr  out  DATA_W  latched address.
- mem_wdata  out  DATA_W  latched store data.
- mem_ack  in  1  one-cycle completion strobe from memory.
- mem_rdata  in  DATA_W  read data; valid with mem_ack.
- ME_Dout  out  DATA_W  latched load data, fed to the MEM/WB register.
- pipe_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- wb_bubble  out  1  MEM/WB captures RegWrite=0 and MemtoReg=0 this edge.
- access_fault  out  1  one-cycle fault pulse.
- stall_cycles  out  32  performance counter (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high): state=IDLE. Counter=0.
  - mem_req, mem_we, mem_addr, mem_wdata, ME_Dout and access_fault are 0.
  - pipe_stall and wb_bubble are 0; stall_cycles=0.
- Reset during BUSY aborts the access: mem_req is 0 from the first cycle after the reset edge, and no fault is raised.
- Output timing: pipe_stall and wb_bubble are combinational from state and inputs; wb_bubble always equals pipe_stall. All other outputs are registered.
- access = ME_MemRead | ME_MemWrite. If both are set, treat it as a write (mem_we=1) with no fault.
- Misaligned: half with ME_Addr[0]=1, or word with ME_Addr[1:0]!=0.
- State IDLE:
  - access=0: pipe_stall=0; stay in IDLE.
  - access=1, aligned: pipe_stall=1. Latch mem_addr, mem_wdata and mem_we; counter=0; next state BUSY.
  - access=1, misaligned: pipe_stall=1; no request. access_fault=1 next cycle; ME_Dout=0; next state DONE.
- State BUSY:
  - mem_req=1 and pipe_stall=1; counter increments each cycle.
  - mem_ack=1: if read, ME_Dout<=mem_rdata; if write, ME_Dout is unchanged. Next state DONE; mem_req=0 next cycle.
  - No ack and counter==TIMEOUT_CYCLES-1: mem_req drops, access_fault pulses, ME_Dout<=0, next state DONE.
- State DONE:
  - pipe_stall=0, so the instruction advances and MEM/WB captures ME_Dout.
  - Next state IDLE unconditionally. The same access never retriggers, because the next ME-stage instruction arrives in IDLE.
- Latency: the access is seen in cycle N and mem_req is high from N+1.
  - With ack in N+1 (zero wait), the state is DONE in N+2 and the instruction leaves MEM at the end of N+2.
  - Stall penalty = 2 + memory wait cycles. A misaligned access costs 1 stall cycle.
- Ignored inputs: mem_ack in IDLE or DONE; mem_rdata without mem_ack.
- Back-to-back accesses: each one passes through IDLE, so there is exactly one unstalled cycle (DONE) between them.
- The fault pulse is exactly 1 cycle, in the DONE cycle.

Optional Feature:
- Macro: MEM_STALL_COUNTER_EN.
- Defined: stall_cycles increments on every clock with pipe_stall=1. It saturates at 32'hFFFFFFFF and is cleared by reset.
- Undefined: stall_cycles is tied to 0 and no counter logic is synthesised; the port still exists.

Test Plan:
- Aligned word load at 0x100, ack on the first req cycle with rdata=0xDEADBEEF → pipe_stall high 2 cycles, ME_Dout=0xDEADBEEF in the DONE cycle, access_fault=0.
- Word store to 0x204 with data 0x12345678, ack after 3 wait cycles → mem_we=1, mem_addr=0x204, mem_wdata=0x12345678, mem_req high 4 cycles, stall 5 cycles.
- Half load at 0x103 → no mem_req, access_fault pulses once, ME_Dout=0, stall 1 cycle.
- Load with ack withheld, TIMEOUT_CYCLES=16 → mem_req high exactly 16 cycles then drops, fault pulse, ME_Dout=0, pipeline resumes.
- Reset asserted on the third BUSY cycle → the cycle after the edge has mem_req=0, pipe_stall=0, state IDLE; a late mem_ack is ignored.
- With MEM_STALL_COUNTER_EN defined: two back-to-back zero-wait loads → stall_cycles=4, with one unstalled cycle between the accesses.
